// File: rtl/shooter_controller.sv
// Per-frame shooter motion: sync vsync, decode WASD, step/clamp sprite.
// Optional SHOOTER_TURN_PAUSE_EN: direction change costs one frame in TURN.
module shooter_controller #(
  parameter int STEP    = 2,
  parameter int X_MIN   = 32,
  parameter int X_MAX   = 576,
  parameter int Y_MIN   = 62,
  parameter int Y_MAX   = 416,
  parameter int X_START = 304,
  parameter int Y_START = 239
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       frame_clk,
  input  logic [7:0] keycode,
  output logic [9:0] ShooterX,
  output logic [9:0] ShooterY,
  output logic [1:0] ShooterFace,
  output logic       Moving
);

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    TURN = 2'b01,
    MOVE = 2'b10
  } state_t;

  localparam logic [10:0] STP = 11'(STEP);
  localparam logic [10:0] XMN = 11'(X_MIN);
  localparam logic [10:0] XMX = 11'(X_MAX);
  localparam logic [10:0] YMN = 11'(Y_MIN);
  localparam logic [10:0] YMX = 11'(Y_MAX);

  localparam logic [1:0] D_UP = 2'b00;
  localparam logic [1:0] D_RT = 2'b01;
  localparam logic [1:0] D_DN = 2'b10;
  localparam logic [1:0] D_LF = 2'b11;

  state_t      state, state_n;
  logic [9:0]  x_n, y_n;
  logic [1:0]  face_n;
  logic        sync1, sync2, dly;
  logic        frame_tick;
  logic        kvalid;
  logic [1:0]  kdir;
  logic        do_step;
  logic [10:0] xinc, xdec, yinc, ydec;
  logic [10:0] xw, yw;

  // vsync synchronizer plus delay flop for rising-edge detect
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      dly   <= 1'b0;
    end else begin
      sync1 <= frame_clk;
      sync2 <= sync1;
      dly   <= sync2;
    end
  end

  assign frame_tick = sync2 & ~dly;

  // keycode to direction
  always_comb begin
    kvalid = 1'b1;
    kdir   = D_UP;
    unique case (1'b1)
      (keycode == 8'h1A): kdir = D_UP;
      (keycode == 8'h07): kdir = D_RT;
      (keycode == 8'h16): kdir = D_DN;
      (keycode == 8'h04): kdir = D_LF;
      default:            kvalid = 1'b0;
    endcase
  end

  // clamped step candidates, 11-bit so nothing wraps
  always_comb begin
    xw   = {1'b0, ShooterX};
    yw   = {1'b0, ShooterY};
    xinc = xw + STP;
    yinc = yw + STP;
    if (xinc > XMX) xinc = XMX;
    if (yinc > YMX) yinc = YMX;
    xdec = (xw < XMN + STP) ? XMN : xw - STP;
    ydec = (yw < YMN + STP) ? YMN : yw - STP;
  end

  // next-state, face and position, all gated by frame_tick
  always_comb begin
    state_n = state;
    face_n  = ShooterFace;
    x_n     = ShooterX;
    y_n     = ShooterY;
    do_step = 1'b0;
    if (frame_tick) begin
      if (!kvalid) begin
        state_n = IDLE;
      end else if (kdir != ShooterFace) begin
        face_n = kdir;
`ifdef SHOOTER_TURN_PAUSE_EN
        state_n = TURN;
`else
        state_n = MOVE;
        do_step = 1'b1;
`endif
      end else begin
        state_n = MOVE;
        do_step = 1'b1;
      end
    end
    if (do_step) begin
      unique case (kdir)
        D_UP: y_n = ydec[9:0];
        D_RT: x_n = xinc[9:0];
        D_DN: y_n = yinc[9:0];
        D_LF: x_n = xdec[9:0];
        default: ;
      endcase
    end
  end

  // state, face and position registers
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state       <= IDLE;
      ShooterFace <= D_UP;
      ShooterX    <= 10'(X_START);
      ShooterY    <= 10'(Y_START);
    end else begin
      state       <= state_n;
      ShooterFace <= face_n;
      ShooterX    <= x_n;
      ShooterY    <= y_n;
    end
  end

  assign Moving = (state == MOVE);

endmodule

// File: tb/tb_shooter_controller.sv
// Directed self-checking bench for shooter_controller.
// Expected values follow SHOOTER_TURN_PAUSE_EN when defined.
module tb_shooter_controller;

  logic       clk;
  logic       rst;
  logic       fclk;
  logic [7:0] key;
  logic [7:0] key2;
  logic [9:0] x, y, x2, y2;
  logic [1:0] face, face2;
  logic       mov, mov2;

  int checks = 0;
  int fails  = 0;
  int maxx;
  int y0;

  shooter_controller dut (
    .Clk(clk), .Reset(rst), .frame_clk(fclk), .keycode(key),
    .ShooterX(x), .ShooterY(y), .ShooterFace(face), .Moving(mov)
  );

  shooter_controller #(.X_START(33)) dut2 (
    .Clk(clk), .Reset(rst), .frame_clk(fclk), .keycode(key2),
    .ShooterX(x2), .ShooterY(y2), .ShooterFace(face2), .Moving(mov2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    checks++;
    if (got != exp) begin
      fails++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic frame(input int hi, input int lo);
    @(negedge clk);
    fclk = 1'b1;
    repeat (hi) @(negedge clk);
    fclk = 1'b0;
    repeat (lo) @(negedge clk);
  endtask

  initial begin
    rst  = 1'b1;
    fclk = 1'b0;
    key  = 8'h00;
    key2 = 8'h00;
    repeat (3) @(negedge clk);
    check("rst_x", x, 304);
    check("rst_y", y, 239);
    check("rst_face", face, 0);
    check("rst_mov", mov, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // turn and move right for three frames
    key = 8'h07;
    frame(3, 3);
    check("tm1_face", face, 1);
`ifdef SHOOTER_TURN_PAUSE_EN
    check("tm1_x", x, 304);
    check("tm1_mov", mov, 0);
    frame(3, 3);
    check("tm2_x", x, 306);
    check("tm2_mov", mov, 1);
    frame(3, 3);
    check("tm3_x", x, 308);
`else
    check("tm1_x", x, 306);
    check("tm1_mov", mov, 1);
    frame(3, 3);
    check("tm2_x", x, 308);
    check("tm2_mov", mov, 1);
    frame(3, 3);
    check("tm3_x", x, 310);
`endif
    check("tm3_mov", mov, 1);
    check("tm3_y", y, 239);

    // idle for two frames
    key = 8'h00;
    frame(3, 3);
    frame(3, 3);
`ifdef SHOOTER_TURN_PAUSE_EN
    check("idle_x", x, 308);
`else
    check("idle_x", x, 310);
`endif
    check("idle_y", y, 239);
    check("idle_face", face, 1);
    check("idle_mov", mov, 0);

    // key held, no frame edges
    key = 8'h16;
    for (int i = 0; i < 10; i++) begin
      repeat (1000) @(negedge clk);
      check("notick_face", face, 1);
      check("notick_y", y, 239);
      check("notick_mov", mov, 0);
    end

    // one long vsync pulse with W held
    key = 8'h1A;
`ifdef SHOOTER_TURN_PAUSE_EN
    y0 = 239;
`else
    y0 = 237;
`endif
    @(negedge clk);
    fclk = 1'b1;
    repeat (2) @(negedge clk);
    check("lv_pre_face", face, 1);
    @(negedge clk);
    check("lv_edge_face", face, 0);
    check("lv_edge_y", y, y0);
    repeat (997) @(negedge clk);
    fclk = 1'b0;
    repeat (3) @(negedge clk);
    check("lv_end_face", face, 0);
    check("lv_end_y", y, y0);

    // walk right into the clamp
    key  = 8'h07;
    maxx = 0;
    for (int i = 0; i < 160; i++) begin
      frame(2, 2);
      if (int'(x) > maxx) maxx = int'(x);
    end
    check("rc_max", maxx, 576);
    check("rc_x", x, 576);
    check("rc_mov", mov, 1);
    check("rc_y", y, y0);

    // left clamp on the X_START=33 instance
    key  = 8'h00;
    key2 = 8'h04;
    frame(3, 3);
    check("lc1_face", face2, 3);
`ifdef SHOOTER_TURN_PAUSE_EN
    check("lc1_x", x2, 33);
    check("lc1_mov", mov2, 0);
`else
    check("lc1_x", x2, 32);
    check("lc1_mov", mov2, 1);
`endif
    for (int i = 0; i < 3; i++) begin
      frame(3, 3);
      check("lc_x", x2, 32);
      check("lc_mov", mov2, 1);
    end
    key2 = 8'h00;

    // async reset mid-frame after motion
    key = 8'h16;
    @(negedge clk);
    fclk = 1'b1;
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    check("ar_x", x, 304);
    check("ar_y", y, 239);
    check("ar_face", face, 0);
    check("ar_mov", mov, 0);
    check("ar_x2", x2, 33);
    fclk = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // first frame after release is detected
    key = 8'h07;
    frame(3, 3);
    check("pr_face", face, 1);
`ifdef SHOOTER_TURN_PAUSE_EN
    check("pr_x", x, 304);
`else
    check("pr_x", x, 306);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end

endmodule

// File: doc/shooter_controller.md
# shooter_controller

Per-frame player-motion controller for the final-project room game. Samples the keyboard keycode once per video frame and advances the shooter's upper-left position and facing direction. Clamps the 32x32 sprite inside the blue floor region. Its `ShooterX`, `ShooterY` and `ShooterFace` outputs drive the colour mapper directly, and a `Moving` flag is exported for animation and sound logic.

## Interface
Parameters:
- `STEP`, 2: pixels moved per frame while moving.
- `X_MIN`, 32: leftmost legal `ShooterX`.
- `X_MAX`, 576: rightmost legal `ShooterX` (floor right edge 607 minus 31).
- `Y_MIN`, 62: topmost legal `ShooterY`.
- `Y_MAX`, 416: bottommost legal `ShooterY` (floor bottom edge 447 minus 31).
- `X_START`, 304: reset value of `ShooterX`.
- `Y_START`, 239: reset value of `ShooterY`.

Ports:
- `Clk`, input, 1: system clock (50 MHz); the single clock domain.
- `Reset`, input, 1: asynchronous, active-high reset.
- `frame_clk`, input, 1: vertical sync, asynchronous to `Clk`; a rising edge marks a frame.
- `keycode`, input, 8: USB HID keycode.
- `ShooterX`, output, 10: sprite upper-left X.
- `ShooterY`, output, 10: sprite upper-left Y.
- `ShooterFace`, output, 2: facing direction; 00 up, 01 right, 10 down, 11 left.
- `Moving`, output, 1: high while the FSM is in MOVE.

## Operation
- `frame_clk` passes through a 2-flop synchronizer, followed by a delay flop for rising-edge detection.
- The detected edge is a 1-cycle `frame_tick`. All state and position updates happen only on `frame_tick`.
- Key decode:
  - 0x1A (W) is up.
  - 0x07 (D) is right.
  - 0x16 (S) is down.
  - 0x04 (A) is left.
  - Any other value is "none".
- FSM states: IDLE, TURN, MOVE. Transitions are evaluated on `frame_tick` only:
  - Key is none: go to IDLE. Position and face hold.
  - Valid key whose direction differs from `ShooterFace`: load `ShooterFace` and go to TURN. Position holds.
  - Valid key whose direction equals `ShooterFace` (from any state): go to MOVE and step the position.
- Step arithmetic uses 11-bit intermediates:
  - Increment: result is min(cur+STEP, MAX).
  - Decrement: if cur < MIN+STEP, the result is MIN; otherwise cur−STEP. There is no underflow or wrap.
  - Only the axis of the current direction changes.
- At a boundary with the key still held, the FSM stays in MOVE and the position stays at the clamp value.
- Reset (asynchronous, any time, including mid-frame or mid-step) immediately forces:
  - `ShooterX` = `X_START`, `ShooterY` = `Y_START`.
  - `ShooterFace` = 00, FSM = IDLE, so `Moving` = 0.
  - Synchronizer and edge flops = 0.
- The first `frame_clk` rise after reset release is detected normally.

## Timing
- Latency: if `frame_clk` is first sampled high at `Clk` edge k, then `frame_tick` is high during cycle k+1..k+2, and outputs change at edge k+2.
- `keycode` is sampled at that same edge k+2 and needs no synchronization beyond setup to `Clk`.
- At most one update per `frame_clk` rising edge. A high level of any duration produces exactly one tick.
- Outputs are registered and hold stable for the full frame, so they are safe for the colour mapper to read combinationally during active video.
- `Moving` is registered and changes on the same edge as position.

## Configuration
- `SHOOTER_TURN_PAUSE_EN` defined: behaviour is exactly as in Operation. A direction change spends one frame in TURN (face updates, no movement), and stepping starts on the next frame.
- `SHOOTER_TURN_PAUSE_EN` undefined:
  - TURN is never entered.
  - A valid key with a different direction loads `ShooterFace` and steps in the new direction on the same tick, then goes to MOVE.
  - The 2-bit state encoding is kept.

## Test plan
- Reset: assert `Reset` mid-frame after movement. The required response is immediate `ShooterX`=304, `ShooterY`=239, `ShooterFace`=00, `Moving`=0, without waiting for a `Clk` edge.
- Turn and move: hold `keycode`=0x07 for 3 frames.
  - With the macro: frame 1 gives face 01, X 304, `Moving` 0; then X 306, then 308 with `Moving` 1.
  - Without the macro: X 306, 308, 310.
- Clamp: `X_START`=33, hold 0x04 with the macro. Frame 1 turns; frame 2 gives X=32; frames 3+ keep X at 32 with `Moving`=1. Separately, hold 0x07 until X reaches 576; it must never exceed 576.
- Idle: after moving, set `keycode`=0x00 for 2 frames. Required response: position unchanged, face unchanged, `Moving`=0.
- No tick: hold 0x16 for 10000 `Clk` cycles with `frame_clk` low. Required response: no output change.
- Long vsync: one `frame_clk` pulse held high for 1000 cycles with 0x1A pressed. Required response: exactly one update, and the first output change occurs 2 `Clk` edges after the first high sample.
